// File: rtl/token_frontend.sv
// token_frontend: parses an ASCII adjacency-list byte stream into fixed-width
// node-name tokens, buffers them in a small FIFO and presents them downstream
// on a ready/valid interface together with per-token flags and counters.
module token_frontend #(
    parameter int unsigned               NAME_LEN   = 3,
    parameter int unsigned               DEPTH      = 8,
    parameter logic [5*NAME_LEN-1:0]     START_NAME = {5'd24, 5'd14, 5'd20},
    parameter logic [5*NAME_LEN-1:0]     END_NAME   = {5'd14, 5'd20, 5'd19},
    parameter int unsigned               CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_vld,
    input  logic [7:0]             i_char,
    output logic                   o_stall,
    output logic                   o_tok_vld,
    input  logic                   i_tok_rdy,
    output logic [5*NAME_LEN-1:0]  o_tok_name,
    output logic                   o_tok_src,
    output logic                   o_tok_eol,
    output logic                   o_tok_start,
    output logic                   o_tok_end,
    output logic                   o_tok_last,
    output logic                   o_error,
    output logic [CNT_W-1:0]       o_line_cnt,
    output logic [CNT_W-1:0]       o_tok_cnt
);

    localparam int unsigned NW  = 5 * NAME_LEN;
    localparam int unsigned EW  = NW + 5;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned LCW = $clog2(NAME_LEN + 1);

    localparam logic [7:0] CH_NL    = 8'h0a;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3a;
    localparam logic [7:0] CH_A     = 8'h61;
    localparam logic [7:0] CH_Z     = 8'h7a;

    typedef enum logic [2:0] {
        S_LSTART,
        S_NAME,
        S_COLON,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [LCW-1:0]     len_q, len_d;
    logic [NW-1:0]      acc_q, acc_d;
    logic               first_q, first_d;
    logic               err_q;
    logic               vld_q;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [CNT_W-1:0]   tok_cnt_q, line_cnt_q;

    logic               full_c;
    logic               accept_c;
    logic               pop_c;
    logic               push_c;
    logic [EW-1:0]      wdata_c;
    logic               tok_inc_c;
    logic               line_inc_c;
    logic               is_letter_c;
    logic [4:0]         letter_c;
    logic [EW-1:0]      head_c;

    // Character classification and handshake terms
    always_comb begin
        is_letter_c = (i_char >= CH_A) && (i_char <= CH_Z);
        letter_c    = 5'(i_char - CH_A);
        full_c      = (count_q == CW'(DEPTH));
        o_stall     = full_c && (state_q != S_DONE) && (state_q != S_ERR);
        accept_c    = i_vld && !o_stall;
        pop_c       = vld_q && i_tok_rdy;
    end

    // Parser next-state, accumulator update and FIFO write request
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        first_d    = first_q;
        push_c     = 1'b0;
        wdata_c    = '0;
        tok_inc_c  = 1'b0;
        line_inc_c = 1'b0;

        if (accept_c && (i_char != CH_CR)) begin
            unique case (state_q)
                S_LSTART: begin
                    if (is_letter_c) begin
                        state_d = S_NAME;
                        len_d   = LCW'(1);
                        acc_d   = NW'(letter_c);
                        first_d = 1'b1;
                    end else if (i_char == CH_NL) begin
                        push_c  = 1'b1;
                        wdata_c = EW'(1);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NAME: begin
                    if (is_letter_c) begin
                        if (len_q < LCW'(NAME_LEN)) begin
                            len_d = len_q + LCW'(1);
                            acc_d = NW'({acc_q, letter_c});
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if ((i_char == CH_COLON) || (i_char == CH_SPACE) ||
                                 (i_char == CH_NL)) begin
                        if (len_q != LCW'(NAME_LEN)) begin
                            state_d = S_ERR;
                        end else if ((i_char == CH_COLON) && !first_q) begin
                            state_d = S_ERR;
                        end else begin
                            push_c     = 1'b1;
                            tok_inc_c  = 1'b1;
                            line_inc_c = (i_char == CH_NL);
                            wdata_c    = {acc_q,
                                          (i_char == CH_COLON),
                                          (i_char == CH_NL),
                                          (acc_q == START_NAME),
                                          (acc_q == END_NAME),
                                          1'b0};
                            if (i_char == CH_COLON) begin
                                state_d = S_COLON;
                            end else if (i_char == CH_SPACE) begin
                                state_d = S_GAP;
                            end else begin
                                state_d = S_LSTART;
                            end
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_COLON: begin
                    state_d = (i_char == CH_SPACE) ? S_GAP : S_ERR;
                end
                S_GAP: begin
                    if (is_letter_c) begin
                        state_d = S_NAME;
                        len_d   = LCW'(1);
                        acc_d   = NW'(letter_c);
                        first_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Parser state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LSTART;
        end else begin
            state_q <= state_d;
        end
    end

    // Name accumulator, letter count, first-token flag and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q   <= '0;
            acc_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            len_q   <= len_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            err_q   <= (state_d == S_ERR);
        end
    end

    // Next FIFO occupancy
    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointers, occupancy and registered valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            vld_q   <= (count_d != '0);
        end
    end

    // FIFO storage; entries are only observed through the occupancy-gated head
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= wdata_c;
        end
    end

    // Line and token counters, free-running modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst) begin
            tok_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            tok_cnt_q  <= tok_cnt_q + CNT_W'(tok_inc_c);
            line_cnt_q <= line_cnt_q + CNT_W'(line_inc_c);
        end
    end

    // Head entry unpacked onto the token outputs, zero when empty
    always_comb begin
        head_c      = vld_q ? mem[rd_ptr_q] : '0;
        o_tok_vld   = vld_q;
        o_tok_name  = head_c[EW-1:5];
        o_tok_src   = head_c[4];
        o_tok_eol   = head_c[3];
        o_tok_start = head_c[2];
        o_tok_end   = head_c[1];
        o_tok_last  = head_c[0];
        o_error     = err_q;
        o_tok_cnt   = tok_cnt_q;
        o_line_cnt  = line_cnt_q;
    end

endmodule
